// File: rtl/morse_pkg.sv
// Shared Morse definitions: element encoding, code table lookup and FSM state type.
// Patterns hold the first element in bit 0, matching the decoder's shift buffer.
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int UNITS_DOT  = 1;
    localparam int UNITS_DASH = 3;
    localparam int UNITS_WORD = 4;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } morse_code_t;

    typedef struct packed {
        logic        valid;
        logic        space;
        morse_code_t code;
    } morse_lookup_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MARK,
        ST_GAP,
        ST_CHAR_GAP,
        ST_WORD_GAP
    } morse_state_t;

    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    endfunction

    // Table entries are written in reading order (first element in bit len-1) and reversed here.
    function automatic morse_lookup_t mk(input logic [2:0] len, input logic [4:0] nat);
        morse_lookup_t r;
        logic [4:0]    rev;
        rev            = {nat[0], nat[1], nat[2], nat[3], nat[4]};
        r.valid        = 1'b1;
        r.space        = 1'b0;
        r.code.len     = len;
        r.code.pattern = rev >> (3'd5 - len);
        return r;
    endfunction

    function automatic morse_lookup_t char_to_morse(input logic [7:0] c);
        morse_lookup_t r;
        r = '0;
        case (c)
            "A": r = mk(3'd2, 5'b00001);
            "B": r = mk(3'd4, 5'b01000);
            "C": r = mk(3'd4, 5'b01010);
            "D": r = mk(3'd3, 5'b00100);
            "E": r = mk(3'd1, 5'b00000);
            "F": r = mk(3'd4, 5'b00010);
            "G": r = mk(3'd3, 5'b00110);
            "H": r = mk(3'd4, 5'b00000);
            "I": r = mk(3'd2, 5'b00000);
            "J": r = mk(3'd4, 5'b00111);
            "K": r = mk(3'd3, 5'b00101);
            "L": r = mk(3'd4, 5'b00100);
            "M": r = mk(3'd2, 5'b00011);
            "N": r = mk(3'd2, 5'b00010);
            "O": r = mk(3'd3, 5'b00111);
            "P": r = mk(3'd4, 5'b00110);
            "Q": r = mk(3'd4, 5'b01101);
            "R": r = mk(3'd3, 5'b00010);
            "S": r = mk(3'd3, 5'b00000);
            "T": r = mk(3'd1, 5'b00001);
            "U": r = mk(3'd3, 5'b00001);
            "V": r = mk(3'd4, 5'b00001);
            "W": r = mk(3'd3, 5'b00011);
            "X": r = mk(3'd4, 5'b01001);
            "Y": r = mk(3'd4, 5'b01011);
            "Z": r = mk(3'd4, 5'b01100);
            "0": r = mk(3'd5, 5'b11111);
            "1": r = mk(3'd5, 5'b01111);
            "2": r = mk(3'd5, 5'b00111);
            "3": r = mk(3'd5, 5'b00011);
            "4": r = mk(3'd5, 5'b00001);
            "5": r = mk(3'd5, 5'b00000);
            "6": r = mk(3'd5, 5'b10000);
            "7": r = mk(3'd5, 5'b11000);
            "8": r = mk(3'd5, 5'b11100);
            "9": r = mk(3'd5, 5'b11110);
            8'h20: r.space = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_tx_fifo.sv
// Character FIFO between the register interface and the keying FSM.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module morse_tx_fifo #(
    parameter  int FIFO_DEPTH = 8,
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNTW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic [7:0]      i_data,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [7:0]      o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [CNTW-1:0] o_count
);
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_rdPtr;
    logic [AW-1:0]   r_wrPtr;
    logic [CNTW-1:0] r_count;
    logic            w_doPush;
    logic            w_doPop;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full   = (r_count == CNTW'(FIFO_DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge i_clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: HPS-written characters are queued and keyed onto morse_out.
// The gap states load the next character directly on expiry so gaps are exact unit multiples.
module morse_encoder #(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] read_address,
    output logic [7:0] read_data,
    input  logic [3:0] write_address,
    input  logic       write_enable,
    input  logic [7:0] write_data,
    output logic       morse_out,
    output logic       busy
);
    import morse_pkg::*;

    localparam int CW   = $clog2(3 * UNIT_CYCLES + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] C_UNIT      = CW'(UNIT_CYCLES * UNITS_DOT);
    localparam logic [CW-1:0] C_DASH      = CW'(UNIT_CYCLES * UNITS_DASH);
    localparam logic [CW-1:0] C_WORD_HEAD = CW'(UNIT_CYCLES * (UNITS_WORD - UNITS_DASH));

    morse_state_t    r_state;
    logic [CW-1:0]   r_count;
    morse_code_t     r_code;
    logic [2:0]      r_elemIdx;
    logic [7:0]      r_curChar;
    logic [7:0]      r_lastChar;
    logic            r_morseOut;
    logic            r_overflow;
    logic            r_badChar;

    logic [7:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic [CNTW-1:0] w_count;
    logic            w_push;
    logic            w_ctrl;
    logic            w_flush;
    logic            w_clear;
    logic            w_pop;
    logic            w_overflow;
    logic            w_badChar;
    logic [7:0]      w_foldChar;
    morse_lookup_t   w_lookup;
    morse_state_t    w_ldState;
    logic [CW-1:0]   w_ldCount;
    logic            w_ldMark;

    assign w_push     = write_enable && (write_address == 4'd1);
    assign w_ctrl     = write_enable && (write_address == 4'd2);
    assign w_flush    = w_ctrl && write_data[1];
    assign w_clear    = w_ctrl && write_data[0];
    assign w_pop      = !w_empty && ((r_state == ST_LOAD) ||
                        ((r_state == ST_CHAR_GAP) && (r_count == CW'(1))));
    assign w_overflow = w_push && w_full && !w_pop;
    assign w_badChar  = w_pop && !w_lookup.valid && !w_lookup.space;
    assign morse_out  = r_morseOut;
    assign busy       = (r_state != ST_IDLE) || !w_empty;

    morse_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_data  (write_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_foldChar = fold_upper(w_head);
        w_lookup   = char_to_morse(w_foldChar);
        w_ldState  = ST_IDLE;
        w_ldCount  = '0;
        w_ldMark   = 1'b0;
        if (w_lookup.valid) begin
            w_ldState = ST_MARK;
            w_ldCount = (w_lookup.code.pattern[0] == DASH) ? C_DASH : C_UNIT;
            w_ldMark  = 1'b1;
        end else if (w_lookup.space) begin
            w_ldState = ST_WORD_GAP;
            w_ldCount = C_WORD_HEAD;
        end
    end

    // A space keys one unit in WORD_GAP and then reuses CHAR_GAP, keeping the counter 3 units wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_code     <= '0;
            r_elemIdx  <= '0;
            r_curChar  <= 8'h00;
            r_lastChar <= 8'h00;
            r_morseOut <= 1'b0;
            r_overflow <= 1'b0;
            r_badChar  <= 1'b0;
        end else begin
            r_morseOut <= 1'b0;
            if (w_pop) begin
                r_state    <= w_ldState;
                r_count    <= w_ldCount;
                r_morseOut <= w_ldMark;
                r_code     <= w_lookup.code;
                r_curChar  <= w_foldChar;
                r_elemIdx  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (!w_empty) r_state <= ST_LOAD;
                    ST_LOAD: r_state <= ST_IDLE;
                    ST_MARK: begin
                        if (r_count == CW'(1)) begin
                            if ((r_elemIdx + 3'd1) < r_code.len) begin
                                r_state   <= ST_GAP;
                                r_count   <= C_UNIT;
                                r_elemIdx <= r_elemIdx + 3'd1;
                            end else begin
                                r_state    <= ST_CHAR_GAP;
                                r_count    <= C_DASH;
                                r_lastChar <= r_curChar;
                            end
                        end else begin
                            r_count    <= r_count - 1'b1;
                            r_morseOut <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (r_count == CW'(1)) begin
                            r_state    <= ST_MARK;
                            r_count    <= (r_code.pattern[r_elemIdx] == DOT) ? C_UNIT : C_DASH;
                            r_morseOut <= 1'b1;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    ST_CHAR_GAP: begin
                        if (r_count == CW'(1)) r_state <= ST_IDLE;
                        else                   r_count <= r_count - 1'b1;
                    end
                    ST_WORD_GAP: begin
                        if (r_count == CW'(1)) begin
                            r_state <= ST_CHAR_GAP;
                            r_count <= C_DASH;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
            if (w_clear) begin
                r_overflow <= 1'b0;
                r_badChar  <= 1'b0;
            end
            if (w_overflow) r_overflow <= 1'b1;
            if (w_badChar)  r_badChar  <= 1'b1;
        end
    end

    always_comb begin
        read_data = 8'h00;
        case (read_address)
            4'd0:    read_data = {3'b000, r_badChar, r_overflow, w_empty, w_full, busy};
            4'd1:    read_data = 8'(w_count);
            4'd3:    read_data = r_lastChar;
            default: read_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES = 4; all driving and sampling on negedges.
module tb_morse_encoder;
    localparam int UNIT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] read_address = 4'd0;
    logic [7:0] read_data;
    logic [3:0] write_address = 4'd0;
    logic       write_enable = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       morse_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    morse_encoder #(.UNIT_CYCLES(UNIT), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_address  (read_address),
        .read_data     (read_data),
        .write_address (write_address),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .morse_out     (morse_out),
        .busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
        write_address = addr;
        write_data    = data;
        write_enable  = 1'b1;
        @(negedge clk);
        write_enable  = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [7:0] d);
        read_address = addr;
        #1;
        d = read_data;
    endtask

    task automatic runLen(input logic level, output int len);
        len = 0;
        while (morse_out === level && len < 200) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic busyRun(output int len);
        len = 0;
        while (busy === 1'b1 && len < 200) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic waitHigh(output int waited);
        waited = 0;
        while (morse_out !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic drainMarks(input int expLen, output int marks, output int badLen, output logic timedOut);
        int curLen = 0;
        int cyc = 0;
        marks = 0;
        badLen = 0;
        while (busy === 1'b1 && cyc < 4000) begin
            if (morse_out === 1'b1) begin
                curLen++;
            end else if (curLen > 0) begin
                marks++;
                if (curLen != expLen) badLen++;
                curLen = 0;
            end
            @(negedge clk);
            cyc++;
        end
        timedOut = (cyc >= 4000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         len;
        int         marks;
        int         badLen;
        logic       timedOut;
        logic       anyHigh;

        repeat (2) @(negedge clk);
        readReg(4'd0, d);  checkOutput("reset STATUS", d, 8'h04);
        readReg(4'd1, d);  checkOutput("reset COUNT", d, 8'h00);
        readReg(4'd3, d);  checkOutput("reset LAST_CHAR", d, 8'h00);
        checkOutput("reset morse_out", morse_out, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single dot: rises after the second edge past the write.
        applyStimulus(4'd1, "E");
        checkOutput("E busy after write", busy, 1'b1);
        checkOutput("E out lat0", morse_out, 1'b0);
        @(negedge clk);
        checkOutput("E out lat1", morse_out, 1'b0);
        @(negedge clk);
        checkOutput("E out rises", morse_out, 1'b1);
        runLen(1'b1, len); checkOutput("E mark len", len, 4);
        busyRun(len);      checkOutput("E tail busy", len, 12);
        readReg(4'd3, d);  checkOutput("E LAST_CHAR", d, 8'h45);

        // Lowercase folds to 'A' (.-).
        @(negedge clk);
        applyStimulus(4'd1, "a");
        waitHigh(len);     checkOutput("a latency", len, 2);
        runLen(1'b1, len); checkOutput("a dot", len, 4);
        runLen(1'b0, len); checkOutput("a intra gap", len, 4);
        runLen(1'b1, len); checkOutput("a dash", len, 12);
        busyRun(len);      checkOutput("a tail busy", len, 12);
        readReg(4'd3, d);  checkOutput("a LAST_CHAR", d, 8'h41);

        // E, space, T: seven units off between marks.
        @(negedge clk);
        applyStimulus(4'd1, "E");
        applyStimulus(4'd1, " ");
        applyStimulus(4'd1, "T");
        waitHigh(len);     checkOutput("EsT latency", len, 0);
        runLen(1'b1, len); checkOutput("EsT E mark", len, 4);
        runLen(1'b0, len); checkOutput("EsT word gap", len, 28);
        runLen(1'b1, len); checkOutput("EsT T mark", len, 12);
        busyRun(len);      checkOutput("EsT tail busy", len, 12);
        readReg(4'd3, d);  checkOutput("EsT LAST_CHAR", d, 8'h54);

        // Bad character.
        @(negedge clk);
        applyStimulus(4'd1, 8'h3F);
        anyHigh = morse_out;
        checkOutput("bad busy after write", busy, 1'b1);
        @(negedge clk);
        anyHigh = anyHigh | morse_out;
        @(negedge clk);
        anyHigh = anyHigh | morse_out;
        checkOutput("bad busy drop", busy, 1'b0);
        checkOutput("bad no mark", anyHigh, 1'b0);
        readReg(4'd0, d);  checkOutput("bad STATUS", d, 8'h14);
        @(negedge clk);
        applyStimulus(4'd2, 8'h01);
        readReg(4'd0, d);  checkOutput("bad cleared STATUS", d, 8'h04);

        // Overflow: 'E' in flight, 8 queued 'E', 9th 'T' dropped.
        @(negedge clk);
        applyStimulus(4'd1, "E");
        @(negedge clk);
        @(negedge clk);
        readReg(4'd1, d);  checkOutput("ovf head popped", d, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 8; i++) applyStimulus(4'd1, "E");
        applyStimulus(4'd1, "T");
        readReg(4'd1, d);  checkOutput("ovf COUNT", d, 8'h08);
        readReg(4'd0, d);  checkOutput("ovf STATUS", d, 8'h0B);
        drainMarks(4, marks, badLen, timedOut);
        checkOutput("ovf drain done", timedOut, 1'b0);
        checkOutput("ovf marks", marks, 8);
        checkOutput("ovf only dots", badLen, 0);
        readReg(4'd3, d);  checkOutput("ovf LAST_CHAR", d, 8'h45);
        @(negedge clk);
        applyStimulus(4'd2, 8'h01);
        readReg(4'd0, d);  checkOutput("ovf cleared STATUS", d, 8'h04);

        // Flush after T is popped: T completes, queued E's vanish.
        @(negedge clk);
        applyStimulus(4'd1, "T");
        applyStimulus(4'd1, "E");
        applyStimulus(4'd1, "E");
        applyStimulus(4'd2, 8'h02);
        readReg(4'd1, d);  checkOutput("flush COUNT", d, 8'h00);
        runLen(1'b1, len); checkOutput("flush T remaining", len, 11);
        busyRun(len);      checkOutput("flush tail busy", len, 12);
        readReg(4'd3, d);  checkOutput("flush LAST_CHAR", d, 8'h54);

        // Asynchronous reset in the middle of a dash.
        @(negedge clk);
        applyStimulus(4'd1, "T");
        applyStimulus(4'd1, "E");
        repeat (3) @(negedge clk);
        checkOutput("pre-reset mark", morse_out, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset drops morse_out", morse_out, 1'b0);
        checkOutput("reset drops busy", busy, 1'b0);
        read_address = 4'd0;
        #1;
        checkOutput("mid reset STATUS", read_data, 8'h04);
        read_address = 4'd1;
        #1;
        checkOutput("mid reset COUNT", read_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Transmit-side counterpart of the button-driven Morse decoder.
- The HPS writes ASCII characters over the same Avalon-style register interface into a small FIFO.
- The block converts each character to dots and dashes and drives a keyed output (LED/buzzer pin) with standard Morse timing.
- It sits beside the decoder in the FPGA fabric, with status readable by the HPS.

Parameters:
- UNIT_CYCLES, default 12_500_000: clk cycles per Morse time unit (250 ms at 50 MHz); minimum 2.
- FIFO_DEPTH, default 8: character FIFO entries; power of two, maximum 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- read_address  in  4  register read address
- read_data  out  8  register read data; combinational (asynchronous) read
- write_address  in  4  register write address
- write_enable  in  1  write strobe, sampled on posedge clk
- write_data  in  8  register write data
- morse_out  out  1  keyed output; 1 = mark (tone/LED on)
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty

Behaviour:
- Register map (all other addresses read 0; writes to them are ignored):
  - addr0 STATUS (R): bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bit4 bad_char (sticky), bits7:5 = 0.
  - addr1 TX_DATA (W): push write_data into the FIFO. If the FIFO is full, the write is dropped and overflow is set.
  - addr1 COUNT (R): FIFO occupancy, 0..FIFO_DEPTH.
  - addr2 CONTROL (W, self-clearing): bit0 = 1 clears overflow and bad_char; bit1 = 1 flushes the FIFO. A character already in flight finishes.
  - addr3 LAST_CHAR (R): last character fully sent (after uppercase folding); reset value 8'h00.
- Reset (async, rst_n = 0):
  - FIFO emptied, sticky bits cleared, FSM to IDLE, counters 0.
  - morse_out = 0, busy = 0, LAST_CHAR = 0.
- Encoding:
  - 'A'-'Z' and '0'-'9' use international Morse; 'a'-'z' fold to uppercase.
  - ' ' (8'h20) is a word gap.
  - Any other code: bad_char is set, no output is produced, and the FSM returns to IDLE.
- Timing, in units:
  - dot mark = 1; dash mark = 3.
  - intra-character gap = 1; inter-character gap = 3 after the last element.
  - space = 4 extra off units, giving 7 total when following a character.
- FSM states: IDLE, LOAD, MARK, GAP, CHAR_GAP, WORD_GAP.
  - IDLE: if FIFO non-empty → LOAD.
  - LOAD: pop one entry, look up length/pattern, element index = 0.
    - Valid character → MARK with count = dot ? UNIT_CYCLES : 3*UNIT_CYCLES.
    - Space → WORD_GAP with count = 4*UNIT_CYCLES.
    - Bad character → IDLE.
  - MARK: morse_out = 1; count decrements. At expiry:
    - more elements remain → GAP (UNIT_CYCLES);
    - otherwise → CHAR_GAP (3*UNIT_CYCLES) and LAST_CHAR updated.
  - GAP: at expiry → MARK for the next element.
  - CHAR_GAP / WORD_GAP: at expiry → IDLE.
  - morse_out is registered and is 1 only in MARK.
- Latency: a TX_DATA write at edge N puts the FIFO non-empty after N; LOAD at N+1; morse_out rises after edge N+2.
- Boundary conditions:
  - Push and pop in the same cycle while full: the push is accepted and no overflow is flagged.
  - Push to an empty FIFO while IDLE: normal latency as above.
  - Flush while LOAD pops: the popped character is still sent.
  - Duration counter width is $clog2(3*UNIT_CYCLES+1) bits.
  - Reset mid-character: morse_out drops immediately (asynchronous).

Decomposition:
- Package morse_pkg holds:
  - DOT/DASH constants;
  - typedef morse_code_t {len[2:0], pattern[4:0]}, with the first element in bit 0 (same bit order as the decoder's buffer);
  - function char_to_morse(byte) returning morse_code_t plus a valid flag;
  - unit-multiple constants 1, 3, 4.
- Sub-module morse_tx_fifo: synchronous FIFO with push/pop/flush, full/empty/count outputs, and parameter FIFO_DEPTH.

Test Plan (UNIT_CYCLES = 4):
- Write 'E' to addr1 at cycle 0 → morse_out high for cycles 3-6, then low. busy falls 12 cycles after morse_out falls. LAST_CHAR = 8'h45.
- Write 'a' → morse_out high 4, low 4, high 12, low 12, then IDLE. LAST_CHAR = 8'h41.
- Write "E", " ", "T" back-to-back → off time between the E mark and the T mark is exactly 28 cycles. The T mark lasts 12 cycles.
- Write 8'h3F ('?') → morse_out stays 0, STATUS bit4 = 1, busy drops within 3 cycles. Writing CONTROL = 8'h01 clears bit4.
- Fill 8 entries while the first character is still queued, then write a 9th → COUNT = 8, full = 1, overflow = 1, and the 9th character is never transmitted.
- Assert rst_n = 0 in the middle of a dash → morse_out = 0 with no clock edge, STATUS reads 8'h04, and the FIFO is empty.
